bram_axis_reader: RTL
=====================

# bram_axis_reader

Read-side counterpart of the AXI-Stream-to-BRAM adapter: fetches 1152-bit lines from a wide BRAM over an inclusive address window and serialises each line into 36 × 32-bit AXI-Stream master beats, LSB word first. Sits between the accelerator's line buffer BRAM and the outbound DMA stream, driven by the same `addr_reload` / start / bound control as the write path.

## Interface
- `DATA_WIDTH`, 32, AXIS beat width
- `LINE_WIDTH`, 1152, BRAM line width; must be a multiple of `DATA_WIDTH`
- `ADDR_WIDTH`, 12, BRAM address width
- `m00_axis_aclk`  in  1  sole clock; all logic rising-edge
- `m00_axis_areset`  in  1  asynchronous, active-high reset
- `addr_reload`  in  1  start pulse; samples start/bound addresses
- `bram_start_addr`  in  ADDR_WIDTH  first line to read
- `bram_bound_addr`  in  ADDR_WIDTH  last line to read, inclusive
- `busy`  out  1  high from accepted reload until last beat accepted
- `done`  out  1  one-cycle pulse after last beat accepted
- `BRAM_CLK`  out  1  equals `m00_axis_aclk`
- `BRAM_EN`  out  1  read enable
- `BRAM_WEN`  out  1  tied 0
- `BRAM_ADDR`  out  ADDR_WIDTH  line address
- `BRAM_OUT`  in  LINE_WIDTH  read data, valid the cycle after `BRAM_EN`
- `m00_axis_tvalid`  out  1  beat valid
- `m00_axis_tdata`  out  DATA_WIDTH  beat data
- `m00_axis_tstrb`  out  DATA_WIDTH/8  all ones when valid, 0 otherwise
- `m00_axis_tlast`  out  1  last beat of last line
- `m00_axis_tready`  in  1  downstream ready

## Operation
- Words per line: W = LINE_WIDTH/DATA_WIDTH = 36; beat k = line[32k+31:32k].
- States: IDLE, FETCH, WAIT, STREAM.
- IDLE: `addr_reload`=1 latches start→`cur_addr`, bound→`end_addr`; go FETCH. If bound < start, treat as bound = start (one line).
- FETCH: `BRAM_EN`=1, `BRAM_ADDR`=`cur_addr`; go WAIT.
- WAIT: at end of cycle capture `BRAM_OUT` into line register, beat counter = 0; go STREAM.
- STREAM: `tvalid`=1, `tdata`=word[cnt]. On `tvalid && tready`: cnt+1. On handshake of cnt=W-1: if `cur_addr == end_addr` → IDLE, `done` pulse next cycle; else `cur_addr`+1 → FETCH.
- `tlast`=1 only at cnt=W-1 on the final line.
- `addr_reload` outside IDLE is ignored; the in-flight transfer is unchanged.
- Address never wraps: terminating compare precedes increment.

## Timing
- Reset (async assert, sync deassert): state IDLE, `busy`=0, `done`=0, `BRAM_EN`=0, `BRAM_ADDR`=0, `BRAM_WEN`=0, `tvalid`=0, `tdata`=0, `tstrb`=0, `tlast`=0, counters 0. Reset mid-stream drops `tvalid` immediately; no partial tail is emitted.
- Reload sampled at edge 0 → `BRAM_EN` cycle 1 → first `tvalid` cycle 3.
- `busy` rises the cycle after reload is sampled.
- While `tvalid && !tready`, `tdata`/`tlast`/`tstrb` are held stable.
- Full throughput within a line: one beat per cycle with `tready` held high.
- Inter-line gap without prefetch: 2 cycles of `tvalid`=0 (FETCH, WAIT).

## Configuration
- `BRAM_READER_PREFETCH_EN` defined: adds a second line register. While STREAM is on a non-final line and the next line has not been fetched, `BRAM_EN` is pulsed for `cur_addr+1` in the cycle after the current line is loaded. On handshake of cnt=W-1 the next line is swapped in and STREAM continues with no bubble. First-line latency is still 3 cycles.
- Undefined: single line register and 2-cycle inter-line gap as described above.

## Test plan
- Reset: hold `m00_axis_areset`=1 → all outputs 0; release with no reload → `busy`=0, `BRAM_EN` never asserts.
- Single line: start=3, bound=3, `BRAM_OUT`={18{32'hcccccccc,32'haaaaaaaa}}, `tready`=1 → 36 beats alternating aaaaaaaa/cccccccc starting with aaaaaaaa, `tlast` only on beat 36, `BRAM_ADDR`=3, `done` pulse once.
- Two lines: start=6, bound=7, line 6 pattern {cc..,aa..}, line 7 pattern {18{32'hbbbbbbbb,32'hdddddddd}} → 72 beats, `tlast` only on beat 72; gap of exactly 2 idle cycles between beat 36 and beat 37 without prefetch, 0 cycles with `BRAM_READER_PREFETCH_EN`.
- Backpressure: drop `tready` for 5 cycles at beat 10 → `tdata` stays at word 10, no beat lost or duplicated, total 36 beats.
- Reload while busy: pulse `addr_reload` with start=0, bound=0 mid-line → ignored, original transfer completes unchanged.
- Reset mid-stream at beat 20 → `tvalid` falls without waiting for a clock edge; a fresh reload restarts from beat 0 of the start line.

Source files
------------

// File: rtl/bram_axis_reader_if.sv
// bram_axis_reader_if
//   AXI-Stream beat bundle for the BRAM line reader.
//   master modport: drives tvalid/tdata/tstrb/tlast and samples tready.
//   slave modport : the mirror image, for the downstream consumer.
//   Parameter DATA_WIDTH sets the beat width; tstrb is DATA_WIDTH/8 bits.
interface bram_axis_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/bram_axis_reader.sv
// bram_axis_reader
//   Reads an inclusive window of wide BRAM lines and serialises each line
//   into LINE_WIDTH/DATA_WIDTH AXI-Stream beats, least-significant word first.
//
// Ports
//   m00_axis_aclk    : sole clock (rising edge); also forwarded as BRAM_CLK
//   m00_axis_areset  : asynchronous active-high reset
//   addr_reload      : start pulse, samples bram_start_addr / bram_bound_addr
//   bram_start_addr  : first line to read
//   bram_bound_addr  : last line to read (inclusive, clamped up to start)
//   busy / done      : transfer in flight / one-cycle completion pulse
//   BRAM_*           : read port of the line buffer BRAM (1-cycle read latency)
//   m00_axis         : AXI-Stream master (bram_axis_reader_if.master)
//
// Build option
//   BRAM_READER_PREFETCH_EN : adds a second line register so the next line is
//   fetched while the current one streams, removing the inter-line bubble.
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for addr_reload
//   S_FETCH  | BRAM_EN asserted for r_cur_addr
//   S_WAIT   | BRAM read data arrives, captured at end of cycle
//   S_STREAM | beats of the current line presented on m00_axis
module bram_axis_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 1152,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_areset,
  input  logic                  addr_reload,
  input  logic [ADDR_WIDTH-1:0] bram_start_addr,
  input  logic [ADDR_WIDTH-1:0] bram_bound_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  BRAM_CLK,
  output logic                  BRAM_EN,
  output logic                  BRAM_WEN,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [LINE_WIDTH-1:0] BRAM_OUT,
  bram_axis_reader_if.master    m00_axis
);
  localparam int W     = LINE_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_STREAM} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_end_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;

  logic                  w_hs;
  logic                  w_last_word;
  logic                  w_final_line;
  logic [ADDR_WIDTH-1:0] w_next_addr;

`ifdef BRAM_READER_PREFETCH_EN
  logic [LINE_WIDTH-1:0] r_next_line;
  logic                  r_next_valid;
  logic                  r_pf_issue;
  logic                  r_pf_cap;
`endif

  assign w_hs         = (r_state == S_STREAM) && m00_axis.tready;
  assign w_last_word  = (r_cnt == LAST_CNT);
  assign w_final_line = (r_cur_addr == r_end_addr);
  assign w_next_addr  = r_cur_addr + 1'b1;

  assign BRAM_CLK = m00_axis_aclk;
  assign BRAM_WEN = 1'b0;
  assign done     = r_done;

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    busy             = (r_state != S_IDLE);
    BRAM_EN          = (r_state == S_FETCH);
    BRAM_ADDR        = r_cur_addr;
    m00_axis.tvalid  = (r_state == S_STREAM);
    m00_axis.tdata   = '0;
    m00_axis.tstrb   = '0;
    m00_axis.tlast   = 1'b0;
`ifdef BRAM_READER_PREFETCH_EN
    if (r_pf_issue) begin
      BRAM_EN   = 1'b1;
      BRAM_ADDR = w_next_addr;
    end
`endif
    if (r_state == S_STREAM) begin
      // the line register shifts right per beat, so the current word is always the LSBs
      m00_axis.tdata = r_line[DATA_WIDTH-1:0];
      m00_axis.tstrb = '1;
      m00_axis.tlast = w_last_word && w_final_line;
    end
    case (r_state)
      S_IDLE:   if (addr_reload) w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_WAIT;
      S_WAIT:   w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_hs && w_last_word) begin
          if (w_final_line) w_state_nxt = S_IDLE;
`ifdef BRAM_READER_PREFETCH_EN
          else if (!r_next_valid) w_state_nxt = S_FETCH;
`else
          else w_state_nxt = S_FETCH;
`endif
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      r_cur_addr   <= '0;
      r_end_addr   <= '0;
      r_line       <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
`ifdef BRAM_READER_PREFETCH_EN
      r_next_line  <= '0;
      r_next_valid <= 1'b0;
      r_pf_issue   <= 1'b0;
      r_pf_cap     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef BRAM_READER_PREFETCH_EN
      r_pf_issue <= 1'b0;
      r_pf_cap   <= r_pf_issue;
      if (r_pf_cap) begin
        r_next_line  <= BRAM_OUT;
        r_next_valid <= 1'b1;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (addr_reload) begin
            r_cur_addr <= bram_start_addr;
            // an inverted window degenerates to a single line at start
            r_end_addr <= (bram_bound_addr < bram_start_addr) ? bram_start_addr
                                                              : bram_bound_addr;
          end
        end
        S_WAIT: begin
          r_line <= BRAM_OUT;
          r_cnt  <= '0;
`ifdef BRAM_READER_PREFETCH_EN
          r_pf_issue <= !w_final_line;
`endif
        end
        S_STREAM: begin
          if (w_hs) begin
            if (w_last_word) begin
              r_cnt <= '0;
              // compare against the bound before incrementing so the address never wraps
              if (w_final_line) begin
                r_done <= 1'b1;
              end else begin
                r_cur_addr <= w_next_addr;
`ifdef BRAM_READER_PREFETCH_EN
                if (r_next_valid) begin
                  r_line       <= r_next_line;
                  r_next_valid <= 1'b0;
                  r_pf_issue   <= (w_next_addr != r_end_addr);
                end
`endif
              end
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_line <= r_line >> DATA_WIDTH;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
